// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter sharing one register-file write port among
// four requesters, with stall freeze and registered grant outputs.
module wb_port_arbiter #(
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [3:0]    req,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [AW-1:0] addr2,
    input  logic [AW-1:0] addr3,
    input  logic          hold,
    output logic [3:0]    grant,
    output logic [1:0]    sel,
    output logic [AW-1:0] waddr,
    output logic          we,
    output logic          busy
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    logic [0:0]    r_state;
    logic [1:0]    r_ptr;
    logic [3:0]    r_grant;
    logic [1:0]    r_sel;
    logic [AW-1:0] r_waddr;
    logic          r_we;

    logic [3:0]    w_gmask;
    logic [3:0]    w_elig;
    logic          w_multi;
    logic          w_found;
    logic [1:0]    w_idx;
    logic [1:0]    w_cand;
    logic [AW-1:0] w_addr;

    // Only a live GRANT cycle can mask its own requester.
    assign w_gmask = (r_state == GRANT) ? r_grant : 4'b0000;
    assign w_elig  = req & ~w_gmask;
    assign w_multi = |(w_elig & (w_elig - 4'd1));
    assign busy    = |w_elig && (hold || w_multi);

    // Scan from lowest priority to highest so the nearest winner
    // after the pointer overwrites any earlier candidate.
    always_comb begin
        w_found = 1'b0;
        w_idx   = r_ptr;
        w_cand  = r_ptr;
        for (int j = 4; j >= 1; j--) begin
            w_cand = r_ptr + 2'(j);
            if (w_elig[w_cand]) begin
                w_found = 1'b1;
                w_idx   = w_cand;
            end
        end
    end

    always_comb begin
        case (w_idx)
            2'd0:    w_addr = addr0;
            2'd1:    w_addr = addr1;
            2'd2:    w_addr = addr2;
            default: w_addr = addr3;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ptr   <= 2'b11;
            r_grant <= 4'b0000;
            r_sel   <= 2'b00;
            r_waddr <= '0;
            r_we    <= 1'b0;
        end else if (hold || !w_found) begin
            r_state <= IDLE;
            r_grant <= 4'b0000;
            r_we    <= 1'b0;
        end else begin
            r_state <= GRANT;
            r_ptr   <= w_idx;
            r_grant <= 4'b0001 << w_idx;
            r_sel   <= w_idx;
            r_waddr <= w_addr;
            r_we    <= (w_addr != '0);
        end
    end

    assign grant = r_grant;
    assign sel   = r_sel;
    assign waddr = r_waddr;
    assign we    = r_we;

endmodule
